// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - gated rising-edge counter for frequency measurement
//
// Counts rising edges of the asynchronous input sig_in over a window of
// GATE_CYCLES clk cycles and latches the saturated count at the end of each
// window. Windows run back to back while enable is high.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       1 = measure; 0 = idle, discard the open window, hold result
//   sig_in       asynchronous measured signal
//   count_out    edges in the last completed window, saturated at 2^CNT_W-1
//   overflow     last completed window exceeded 2^CNT_W-1 edges
//   valid        one-cycle pulse when count_out/overflow update
//   gate_active  high while a window is being counted

module freq_gate_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow,
  output logic             valid,
  output logic             gate_active
);

  localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);
  // edge_cnt parks at 2^CNT_W so overflow cannot be lost by wrapping
  localparam logic [CNT_W:0]     EDGE_SAT   = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W+1:0]   CNT_MAX    = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]     count_out_q, count_out_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
  logic                 gate_active_q, gate_active_d;

  logic                 sync_out;
  logic                 rise;
  logic [CNT_W+1:0]     total;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  // A rise seen in the terminal cycle still belongs to the closing window
  assign total    = {1'b0, edge_cnt_q} + (CNT_W+2)'(rise);

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d        = sync_out;
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    valid_d       = 1'b0;

    if (!enable) begin
      // Dropping enable abandons any open window without touching the result
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      gate_cnt_d  = '0;
      edge_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // Wait for the synchronizer and edge detector to hold only
          // post-reset samples so no phantom rise opens the window
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = ST_COUNT;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        ST_COUNT: begin
          if (gate_cnt_q == GATE_LAST) begin
            gate_cnt_d  = '0;
            edge_cnt_d  = '0;
            count_out_d = (total > CNT_MAX) ? {CNT_W{1'b1}} : total[CNT_W-1:0];
            overflow_d  = (total > CNT_MAX);
            valid_d     = 1'b1;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            if (rise && (edge_cnt_q != EDGE_SAT)) begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      endcase
    end

    gate_active_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FLUSH;
      sync_q        <= '0;
      prev_q        <= 1'b0;
      flush_cnt_q   <= '0;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      count_out_q   <= '0;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      gate_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      flush_cnt_q   <= flush_cnt_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_out_q   <= count_out_d;
      overflow_q    <= overflow_d;
      valid_q       <= valid_d;
      gate_active_q <= gate_active_d;
    end
  end

  assign count_out   = count_out_q;
  assign overflow    = overflow_q;
  assign valid       = valid_q;
  assign gate_active = gate_active_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - randomized scoreboard bench for freq_gate_counter

module tb_freq_gate_counter;

  localparam int GATE = 100;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;

  logic [11:0] c12;
  logic        ov12, v12, ga12;
  logic [3:0]  c4;
  logic        ov4, v4, ga4;

  int checks = 0;
  int failures = 0;

  freq_gate_counter #(.GATE_CYCLES(GATE), .SYNC_STAGES(SYNC), .CNT_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .count_out(c12), .overflow(ov12), .valid(v12), .gate_active(ga12)
  );

  freq_gate_counter #(.GATE_CYCLES(GATE), .SYNC_STAGES(SYNC), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .count_out(c4), .overflow(ov4), .valid(v4), .gate_active(ga4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ov;
  } res_t;

  res_t q12[$];
  res_t q4[$];

  // Reference model: sig_in history per clock edge, run length of enabled
  // non-reset edges, and window start edge. A window's result is the number
  // of 0->1 transitions in the sampled history, as they reach the detector.
  bit s_hist[$];
  int run = 0;
  bit counting = 0;
  int wstart = 0;
  int hold12 = 0;
  int hold4 = 0;
  bit hov12 = 0;
  bit hov4 = 0;
  int windows = 0;

  always @(posedge clk) begin
    int n;
    int total;
    bit good;
    res_t r;
    n = s_hist.size();
    s_hist.push_back(sig_in);
    good = !rst && enable;
    if (rst) begin
      hold12 = 0; hold4 = 0; hov12 = 0; hov4 = 0;
    end
    if (!good) begin
      run = 0;
      counting = 0;
    end else begin
      run++;
      if (run == SYNC + 1) begin
        counting = 1;
        wstart = n;
      end else if (counting && n == wstart + GATE) begin
        total = 0;
        for (int c = wstart; c < wstart + GATE; c++)
          if (s_hist[c-1] && !s_hist[c-2]) total++;
        r.cnt = (total > 4095) ? 4095 : total;
        r.ov  = (total > 4095);
        q12.push_back(r);
        hold12 = r.cnt; hov12 = r.ov;
        r.cnt = (total > 15) ? 15 : total;
        r.ov  = (total > 15);
        q4.push_back(r);
        hold4 = r.cnt; hov4 = r.ov;
        windows++;
        wstart = n;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse, otherwise checks that
  // results hold and that no expected pulse was skipped.
  always @(negedge clk) begin
    res_t r;
    chk("gate_active12", int'(ga12), int'(counting));
    chk("gate_active4", int'(ga4), int'(counting));
    if (v12) begin
      if (q12.size() == 0) begin
        chk("unexpected_valid12", 1, 0);
      end else begin
        r = q12.pop_front();
        chk("count12", int'(c12), r.cnt);
        chk("overflow12", int'(ov12), int'(r.ov));
      end
    end else begin
      chk("missing_valid12", q12.size(), 0);
      chk("hold_count12", int'(c12), hold12);
      chk("hold_overflow12", int'(ov12), int'(hov12));
    end
    if (v4) begin
      if (q4.size() == 0) begin
        chk("unexpected_valid4", 1, 0);
      end else begin
        r = q4.pop_front();
        chk("count4", int'(c4), r.cnt);
        chk("overflow4", int'(ov4), int'(r.ov));
      end
    end else begin
      chk("missing_valid4", q4.size(), 0);
      chk("hold_count4", int'(c4), hold4);
      chk("hold_overflow4", int'(ov4), int'(hov4));
    end
  end

  int ph = 0;

  task automatic drive(input logic r, input logic e, input logic s);
    @(posedge clk);
    #1;
    rst = r;
    enable = e;
    sig_in = s;
  endtask

  task automatic wave(input int ncyc, input int hi, input int lo, input logic e);
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b0, e, (ph % (hi + lo)) < hi);
      ph++;
    end
  endtask

  initial begin
    int hi, lo, len, kind;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    // Idle input: first window reports zero
    wave(110, 1, 10000, 1'b1);
    // 10-cycle period, several back-to-back windows
    ph = 0;
    wave(330, 5, 5, 1'b1);
    // Fast input saturates the narrow instance, then a sparse window
    wave(220, 2, 2, 1'b1);
    wave(220, 16, 17, 1'b1);
    // Reset mid-window
    wave(73, 5, 5, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    wave(230, 5, 5, 1'b1);
    // Enable dropped for 20 cycles mid-window
    wave(45, 5, 5, 1'b1);
    wave(20, 5, 5, 1'b0);
    wave(230, 5, 5, 1'b1);
    // Maximum countable rate
    wave(210, 1, 1, 1'b1);

    for (int k = 0; k < 25; k++) begin
      hi   = $urandom_range(1, 9);
      lo   = $urandom_range(1, 9);
      len  = $urandom_range(40, 260);
      kind = $urandom_range(0, 5);
      ph   = $urandom_range(0, 17);
      if (kind == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++)
          drive(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        wave($urandom_range(1, 30), hi, lo, 1'b0);
      end
      wave(len, hi, lo, 1'b1);
    end

    wave(5, 1, 1, 1'b1);
    @(negedge clk);
    #1;
    chk("drain12", q12.size(), 0);
    chk("drain4", q4.size(), 0);
    checks++;
    if (windows < 20) begin
      failures++;
      $display("FAIL too_few_windows: got %0d expected at least 20", windows);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
